// File: rtl/adc_pipe_pkg.sv
// Shared definitions for the pipelined add/subtract unit: opcode encodings and the
// slice-width helper used by adc_pipe and adc_pipe_slice.
package adc_pipe_pkg;

   localparam logic ADC_OP_ADD = 1'b0;
   localparam logic ADC_OP_SUB = 1'b1;

   function automatic int unsigned slice_width(input int unsigned width,
                                               input int unsigned stages);
      return width / stages;
   endfunction

endpackage

// File: rtl/adc_pipe_slice.sv
// One carry-chain slice: a SliceW-bit adder with carry-in feeding its stage register
// (sum, carry-out, valid). Data only loads on a valid beat so the outputs hold otherwise.
module adc_pipe_slice
   import adc_pipe_pkg::*;
#(
   parameter int unsigned SliceW = 8
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SliceW-1:0] a_i,
   input  logic [SliceW-1:0] b_i,
   input  logic              ci_i,
   input  logic              valid_i,
   input  logic              ld_i,
   output logic [SliceW-1:0] sum_o,
   output logic              co_o,
   output logic              valid_o
);

   logic [SliceW:0]   sum_d;
   logic [SliceW-1:0] sum_q;
   logic              co_q;
   logic              valid_q;

   assign sum_d = {1'b0, a_i} + {1'b0, b_i} + {{SliceW{1'b0}}, ci_i};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sum_q   <= '0;
         co_q    <= 1'b0;
         valid_q <= 1'b0;
      end else begin
         if (ld_i) begin
            valid_q <= valid_i;
         end
         if (ld_i && valid_i) begin
            sum_q <= sum_d[SliceW-1:0];
            co_q  <= sum_d[SliceW];
         end
      end
   end

   assign sum_o   = sum_q;
   assign co_o    = co_q;
   assign valid_o = valid_q;

endmodule

// File: rtl/adc_pipe.sv
// Pipelined WIDTH-bit add/subtract with carry/borrow-in, split into STAGES registered
// carry slices with valid/ready on both sides. ADC_PIPE_FLAGS_EN adds OV and Z outputs.
module adc_pipe
   import adc_pipe_pkg::*;
#(
   parameter int unsigned WIDTH  = 32,
   parameter int unsigned STAGES = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             C0,
   input  logic             SUB,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] S,
`ifdef ADC_PIPE_FLAGS_EN
   output logic             OV,
   output logic             Z,
`endif
   output logic             Co
);

   localparam int unsigned SW = slice_width(WIDTH, STAGES);

   if (WIDTH % STAGES != 0) begin : g_bad_width
      $error("adc_pipe: WIDTH must be a multiple of STAGES");
   end

   // Subtract is A + ~B + ~C0, so the borrow-in is inverted along with B.
   logic [WIDTH-1:0] a_eff;
   logic [WIDTH-1:0] b_eff;
   logic             c_eff;

   assign a_eff = A;
   assign b_eff = (SUB == ADC_OP_SUB) ? ~B : B;
   assign c_eff = (SUB == ADC_OP_SUB) ? ~C0 : C0;

   logic [STAGES-1:0] v;
   logic [STAGES-1:0] v_in;
   logic [STAGES-1:0] ld;
   logic [STAGES-1:0] co;
   logic [SW-1:0]     slice_s [STAGES];

   // Per-stage beat context: operands still to be added and result bits already done.
   logic [WIDTH-1:0] a_q   [STAGES];
   logic [WIDTH-1:0] b_q   [STAGES];
   logic [WIDTH-1:0] lo_q  [STAGES];
   logic [WIDTH-1:0] sum_w [STAGES];
   logic [WIDTH-1:0] src_a [STAGES];
   logic [WIDTH-1:0] src_b [STAGES];
   logic [WIDTH-1:0] src_lo[STAGES];

   // A stage may load when empty or when everything downstream moves; bubbles collapse.
   always_comb begin
      logic rdy;
      rdy = out_ready;
      ld  = '0;
      for (int k = int'(STAGES) - 1; k >= 0; k--) begin
         ld[k] = !v[k] || rdy;
         rdy   = ld[k];
      end
   end

   assign in_ready = ld[0];

   always_comb begin
      v_in      = '0;
      v_in[0]   = in_valid;
      src_a[0]  = a_eff;
      src_b[0]  = b_eff;
      src_lo[0] = '0;
      for (int k = 1; k < int'(STAGES); k++) begin
         v_in[k]   = v[k-1];
         src_a[k]  = a_q[k-1];
         src_b[k]  = b_q[k-1];
         src_lo[k] = sum_w[k-1];
      end
   end

   always_comb begin
      for (int k = 0; k < int'(STAGES); k++) begin
         sum_w[k]             = lo_q[k];
         sum_w[k][k*SW +: SW] = slice_s[k];
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < int'(STAGES); k++) begin
            a_q[k]  <= '0;
            b_q[k]  <= '0;
            lo_q[k] <= '0;
         end
      end else begin
         for (int k = 0; k < int'(STAGES); k++) begin
            if (ld[k] && v_in[k]) begin
               a_q[k]  <= src_a[k];
               b_q[k]  <= src_b[k];
               lo_q[k] <= src_lo[k];
            end
         end
      end
   end

   for (genvar k = 0; k < int'(STAGES); k++) begin : g_slice
      logic [SW-1:0] sa;
      logic [SW-1:0] sb;
      logic          sc;

      if (k == 0) begin : g_first
         assign sa = a_eff[SW-1:0];
         assign sb = b_eff[SW-1:0];
         assign sc = c_eff;
      end else begin : g_rest
         assign sa = a_q[k-1][k*SW +: SW];
         assign sb = b_q[k-1][k*SW +: SW];
         assign sc = co[k-1];
      end

      adc_pipe_slice #(
         .SliceW(SW)
      ) u_slice (
         .clk    (clk),
         .rst_n  (rst_n),
         .a_i    (sa),
         .b_i    (sb),
         .ci_i   (sc),
         .valid_i(v_in[k]),
         .ld_i   (ld[k]),
         .sum_o  (slice_s[k]),
         .co_o   (co[k]),
         .valid_o(v[k])
      );
   end

   assign out_valid = v[STAGES-1];
   assign S         = sum_w[STAGES-1];
   assign Co        = co[STAGES-1];

`ifdef ADC_PIPE_FLAGS_EN
   // b_q holds the effective (possibly inverted) B, so one rule covers add and subtract.
   logic a_sign;
   logic b_sign;

   assign a_sign = a_q[STAGES-1][WIDTH-1];
   assign b_sign = b_q[STAGES-1][WIDTH-1];
   assign OV     = out_valid && (a_sign == b_sign) && (S[WIDTH-1] != a_sign);
   assign Z      = out_valid && (S == '0);
`endif

endmodule

// File: tb/tb_adc_pipe.sv
// Self-checking bench for adc_pipe: constant vector table, backpressure and reset
// sequences, then randomized traffic against an arithmetic reference model.
module tb_adc_pipe;

   localparam int unsigned WIDTH  = 32;
   localparam int unsigned STAGES = 4;

   logic             clk;
   logic             rst_n;
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             C0;
   logic             SUB;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] S;
   logic             Co;
`ifdef ADC_PIPE_FLAGS_EN
   logic             OV;
   logic             Z;
`endif

   adc_pipe #(
      .WIDTH (WIDTH),
      .STAGES(STAGES)
   ) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .A        (A),
      .B        (B),
      .C0       (C0),
      .SUB      (SUB),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .S        (S),
`ifdef ADC_PIPE_FLAGS_EN
      .OV       (OV),
      .Z        (Z),
`endif
      .Co       (Co)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] s;
      logic        co;
      logic        ov;
      logic        z;
   } res_t;

   typedef struct {
      logic        sub;
      logic        c0;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] s;
      logic        co;
      logic        ov;
      logic        z;
   } vec_t;

   int   n_checks = 0;
   int   n_fail   = 0;
   res_t exp_q[$];
   int   occ = 0;
   int   n_out = 0;
   logic prev_stall = 1'b0;
   logic [31:0] prev_s;
   logic prev_co;
   logic seen_in_ready;
   logic seen_in_fire;
   logic seen_out_fire;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference: plain integer arithmetic from the operation's definition.
   function automatic res_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic c0, input logic sub);
      res_t        r;
      logic [32:0] full;
      logic [32:0] rhs;
      longint      sa;
      longint      sb;
      longint      res;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      if (!sub) begin
         full = {1'b0, a} + {1'b0, b} + 33'(c0);
         r.s  = full[31:0];
         r.co = full[32];
         res  = sa + sb + longint'(c0);
      end else begin
         rhs  = {1'b0, b} + 33'(c0);
         r.co = ({1'b0, a} >= rhs);
         full = {1'b0, a} - rhs;
         r.s  = full[31:0];
         res  = sa - sb - longint'(c0);
      end
      r.ov = (res > 64'sd2147483647) || (res < -64'sd2147483648);
      r.z  = (r.s == 32'h0);
      return r;
   endfunction

   // One clock cycle with inputs already driven; checks handshake and output beats.
   task automatic cycle();
      res_t e;
      #1;
      seen_in_ready = in_ready;
      seen_in_fire  = in_valid && in_ready;
      seen_out_fire = out_valid && out_ready;
      chk("in_ready", in_ready, (occ < int'(STAGES)) || out_ready);
      if (prev_stall) begin
         chk("hold_valid", out_valid, 1'b1);
         chk("hold_s", S, prev_s);
         chk("hold_co", Co, prev_co);
      end
      if (exp_q.size() == 0) chk("idle_valid", out_valid, 1'b0);
      if (seen_in_fire) begin
         exp_q.push_back(model(A, B, C0, SUB));
         occ++;
      end
      if (seen_out_fire && exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("out_s", S, e.s);
         chk("out_co", Co, e.co);
`ifdef ADC_PIPE_FLAGS_EN
         chk("out_ov", OV, e.ov);
         chk("out_z", Z, e.z);
`endif
         occ--;
         n_out++;
      end
      prev_stall = out_valid && !out_ready;
      prev_s     = S;
      prev_co    = Co;
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] pick();
      case ($urandom % 6)
         0:       return 32'h0;
         1:       return 32'hffffffff;
         2:       return 32'h7fffffff;
         3:       return 32'h80000000;
         default: return $urandom;
      endcase
   endfunction

   vec_t vec[12];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int idx;
      int lat;
      int cyc;
      int sent;
      vec[0]  = '{1'b0, 1'b0, 32'hffffffff, 32'hffffffff, 32'hfffffffe, 1'b1, 1'b0, 1'b0};
      vec[1]  = '{1'b0, 1'b1, 32'd129, 32'd20, 32'd150, 1'b0, 1'b0, 1'b0};
      vec[2]  = '{1'b0, 1'b1, 32'd27, 32'd19, 32'd47, 1'b0, 1'b0, 1'b0};
      vec[3]  = '{1'b0, 1'b1, 32'd157, 32'd29, 32'd187, 1'b0, 1'b0, 1'b0};
      vec[4]  = '{1'b1, 1'b0, 32'd27, 32'd19, 32'd8, 1'b1, 1'b0, 1'b0};
      vec[5]  = '{1'b1, 1'b0, 32'd19, 32'd27, 32'hfffffff8, 1'b0, 1'b0, 1'b0};
      vec[6]  = '{1'b1, 1'b1, 32'd68, 32'd37, 32'd30, 1'b1, 1'b0, 1'b0};
      vec[7]  = '{1'b0, 1'b0, 32'h7fffffff, 32'd1, 32'h80000000, 1'b0, 1'b1, 1'b0};
      vec[8]  = '{1'b1, 1'b0, 32'd5, 32'd5, 32'd0, 1'b1, 1'b0, 1'b1};
      vec[9]  = '{1'b0, 1'b1, 32'hffffffff, 32'd0, 32'd0, 1'b1, 1'b0, 1'b1};
      vec[10] = '{1'b1, 1'b0, 32'h80000000, 32'd1, 32'h7fffffff, 1'b1, 1'b1, 1'b0};
      vec[11] = '{1'b1, 1'b1, 32'd0, 32'd0, 32'hffffffff, 1'b0, 1'b0, 1'b0};

      // Reset state.
      rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      A = '0; B = '0; C0 = 1'b0; SUB = 1'b0;
      #2;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_s", S, 32'h0);
      chk("rst_co", Co, 1'b0);
`ifdef ADC_PIPE_FLAGS_EN
      chk("rst_ov", OV, 1'b0);
      chk("rst_z", Z, 1'b0);
`endif
      @(posedge clk); @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("post_rst_in_ready", in_ready, 1'b1);
      chk("post_rst_out_valid", out_valid, 1'b0);

      // Vector table back-to-back, no backpressure: result exactly STAGES cycles later.
      out_ready = 1'b1;
      for (int t = 0; t < 12 + int'(STAGES) + 1; t++) begin
         idx = t - int'(STAGES);
         if (idx >= 0 && idx < 12) begin
            chk($sformatf("tbl%0d_valid", idx), out_valid, 1'b1);
            chk($sformatf("tbl%0d_s", idx), S, vec[idx].s);
            chk($sformatf("tbl%0d_co", idx), Co, vec[idx].co);
`ifdef ADC_PIPE_FLAGS_EN
            chk($sformatf("tbl%0d_ov", idx), OV, vec[idx].ov);
            chk($sformatf("tbl%0d_z", idx), Z, vec[idx].z);
`endif
         end else begin
            chk($sformatf("tbl_t%0d_idle", t), out_valid, 1'b0);
         end
         if (t < 12) begin
            in_valid = 1'b1; A = vec[t].a; B = vec[t].b; C0 = vec[t].c0; SUB = vec[t].sub;
         end else begin
            in_valid = 1'b0;
         end
         @(posedge clk); #1;
      end

      // Backpressure: 6 beats, out_ready low in cycles 3..8.
      sent = 0; n_out = 0; cyc = 0;
      while ((sent < 6 || exp_q.size() > 0) && cyc < 60) begin
         out_ready = !(cyc >= 3 && cyc <= 8);
         in_valid  = (sent < 6);
         A = 32'd1000 * 32'(sent + 1); B = 32'(sent * 7); C0 = sent[0]; SUB = sent[1];
         cycle();
         if (seen_in_fire) sent++;
         if (cyc == 4) chk("bp_in_ready_low", seen_in_ready, 1'b0);
         if (cyc == 9) begin
            chk("bp_resume_in", seen_in_fire, 1'b1);
            chk("bp_resume_out", seen_out_fire, 1'b1);
         end
         cyc++;
      end
      chk("bp_all_out", 64'(n_out), 64'd6);

      // Reset with 3 beats in flight, the oldest stalled at the output.
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         in_valid = 1'b1; A = 32'd100 + 32'(i); B = 32'(i + 1); C0 = 1'b0; SUB = 1'b0;
         cycle();
      end
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 10) begin
         cycle();
         cyc++;
      end
      chk("rst_mid_pre_valid", out_valid, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("rst_mid_valid", out_valid, 1'b0);
      chk("rst_mid_s", S, 32'h0);
      chk("rst_mid_co", Co, 1'b0);
      exp_q.delete(); occ = 0; prev_stall = 1'b0;
      @(posedge clk); #3;
      rst_n = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b1;
      for (int i = 0; i < 6; i++) cycle();
      in_valid = 1'b1; A = 32'd500; B = 32'd123; C0 = 1'b1; SUB = 1'b1;
      cycle();
      in_valid = 1'b0;
      lat = 1;
      while (!out_valid && lat < 12) begin
         cycle();
         lat++;
      end
      chk("rst_latency", 64'(lat), 64'(STAGES));
      chk("rst_after_s", S, 32'd376);
      cycle();

      // Randomized traffic.
      for (int i = 0; i < 500; i++) begin
         in_valid  = ($urandom % 10) < 7;
         out_ready = ($urandom % 10) < 6;
         A = pick(); B = pick(); C0 = $urandom; SUB = $urandom;
         cycle();
      end
      in_valid = 1'b0; out_ready = 1'b1;
      cyc = 0;
      while (exp_q.size() > 0 && cyc < 50) begin
         cycle();
         cyc++;
      end
      chk("drain_empty", 64'(exp_q.size()), 64'd0);
      chk("drain_idle", out_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
